// File: rtl/cruise_pkg.sv
// Shared types and saturating arithmetic for the cruise speed regulator.
package cruise_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_HOLD   = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_DECEL  = 3'd3,
        ST_PAUSED = 3'd4
    } state_t;

    // One spare bit above the operand width, so the sum cannot wrap before clamping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? 32'd0 : a - b;
    endfunction

endpackage

// File: rtl/cruise_step_timer.sv
// Decision pacing counter: wraps 0..STEP_CYCLES-1 while enabled, tick on the last count.
// Zero latency from count to tick; held at 0 when disabled or cleared, never stalls.
module cruise_step_timer #(
    parameter int STEP_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cruise_speed_regulator.sv
// Cruise mode FSM driving the comparator B operand and accel/decel commands.
// Commands change one cycle after a tick or control event; no backpressure, decisions every STEP_CYCLES.
module cruise_speed_regulator
    import cruise_pkg::*;
#(
    parameter int W           = 8,
    parameter int STEP_CYCLES = 16,
    parameter int ADJ_STEP    = 1,
    parameter int MAX_SPEED   = 200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cruise_en,
    input  logic         set_p,
    input  logic         resume_p,
    input  logic         inc_p,
    input  logic         dec_p,
    input  logic         brake,
    input  logic [W-1:0] speed_in,
    input  logic         cmp_l,
    input  logic         cmp_eq,
    input  logic         cmp_g,
    output logic [W-1:0] target,
    output logic         accel,
    output logic         decel,
    output logic         engaged,
    output logic         cmp_fault
);
    state_t       state, state_nxt;
    logic [2:0]   cmp_q;
    logic         tick, tmr_clr, engaged_st, fault_set;
    logic         accel_nxt, decel_nxt, engaged_nxt;
    logic [W-1:0] target_nxt;

    assign engaged_st = (state == ST_HOLD) || (state == ST_ACCEL) || (state == ST_DECEL);

    cruise_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tmr_clr),
        .en   (engaged_st),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            target    <= '0;
            accel     <= 1'b0;
            decel     <= 1'b0;
            engaged   <= 1'b0;
            cmp_fault <= 1'b0;
            cmp_q     <= 3'b000;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            accel     <= accel_nxt;
            decel     <= decel_nxt;
            engaged   <= engaged_nxt;
            cmp_fault <= cmp_fault | fault_set;
            cmp_q     <= {cmp_l, cmp_eq, cmp_g};
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        fault_set = 1'b0;
        if (!cruise_en) begin
            state_nxt = ST_OFF;
        end else if (brake) begin
            if (engaged_st) state_nxt = ST_PAUSED;
        end else if (set_p) begin
            state_nxt = ST_HOLD;
            tmr_clr   = 1'b1;
        end else if (resume_p) begin
            if (state == ST_PAUSED) begin
                state_nxt = ST_HOLD;
                tmr_clr   = 1'b1;
            end
        end else if (tick) begin
            // cmp_q is {L, EQ, G}; anything not one-hot is a broken comparator.
            case (cmp_q)
                3'b100:  state_nxt = ST_ACCEL;
                3'b001:  state_nxt = ST_DECEL;
                3'b010:  state_nxt = ST_HOLD;
                default: begin
                    state_nxt = ST_HOLD;
                    fault_set = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        accel_nxt   = (state_nxt == ST_ACCEL);
        decel_nxt   = (state_nxt == ST_DECEL);
        engaged_nxt = (state_nxt == ST_HOLD) || (state_nxt == ST_ACCEL) || (state_nxt == ST_DECEL);
        target_nxt  = target;
        if (cruise_en && !brake && set_p) begin
            target_nxt = W'(sat_add(32'(speed_in), 32'd0, 32'(MAX_SPEED)));
        end else if (cruise_en && (state != ST_OFF) && (inc_p ^ dec_p)) begin
            if (inc_p) target_nxt = W'(sat_add(32'(target), 32'(ADJ_STEP), 32'(MAX_SPEED)));
            else       target_nxt = W'(sat_sub(32'(target), 32'(ADJ_STEP)));
        end
    end

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// Scoreboarded, table-driven bench for the cruise speed regulator.
module tb_cruise_speed_regulator;
    localparam int W = 8;

    typedef struct {
        logic       en, set, res, inc, dec, brk;
        logic [7:0] spd;
        logic [2:0] cmp;
        logic [7:0] e_tgt;
        logic       e_acc, e_dec, e_eng, e_flt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cruise_en = 1'b0, set_p = 1'b0, resume_p = 1'b0;
    logic         inc_p = 1'b0, dec_p = 1'b0, brake = 1'b0;
    logic [W-1:0] speed_in = '0;
    logic         cmp_l = 1'b0, cmp_eq = 1'b0, cmp_g = 1'b0;
    logic [W-1:0] target;
    logic         accel, decel, engaged, cmp_fault;

    int   n_checks = 0;
    int   n_fail = 0;
    int   step_no = 0;
    vec_t tbl[$];
    vec_t sb[$];

    localparam logic [2:0] L = 3'b100, E = 3'b010, G = 3'b001, LG = 3'b101;

    cruise_speed_regulator #(.W(W), .STEP_CYCLES(16), .ADJ_STEP(1), .MAX_SPEED(200)) dut (
        .clk(clk), .rst_n(rst_n), .cruise_en(cruise_en), .set_p(set_p),
        .resume_p(resume_p), .inc_p(inc_p), .dec_p(dec_p), .brake(brake),
        .speed_in(speed_in), .cmp_l(cmp_l), .cmp_eq(cmp_eq), .cmp_g(cmp_g),
        .target(target), .accel(accel), .decel(decel), .engaged(engaged),
        .cmp_fault(cmp_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, step %0d", step_no);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, set, res, inc, dec, brk,
                                input logic [7:0] spd, input logic [2:0] cmp,
                                input logic [7:0] tgt, input logic a, d, e, f);
        vec_t v;
        v.en = en; v.set = set; v.res = res; v.inc = inc; v.dec = dec; v.brk = brk;
        v.spd = spd; v.cmp = cmp; v.e_tgt = tgt;
        v.e_acc = a; v.e_dec = d; v.e_eng = e; v.e_flt = f;
        return v;
    endfunction

    task automatic add(input vec_t v, input int n);
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic run_table();
        vec_t v, x;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            cruise_en = v.en; set_p = v.set; resume_p = v.res;
            inc_p = v.inc; dec_p = v.dec; brake = v.brk; speed_in = v.spd;
            {cmp_l, cmp_eq, cmp_g} = v.cmp;
            sb.push_back(v);
            @(posedge clk);
            #1;
            step_no++;
            x = sb.pop_front();
            chk("target", step_no, int'(target), int'(x.e_tgt));
            chk("accel", step_no, int'(accel), int'(x.e_acc));
            chk("decel", step_no, int'(decel), int'(x.e_dec));
            chk("engaged", step_no, int'(engaged), int'(x.e_eng));
            chk("cmp_fault", step_no, int'(cmp_fault), int'(x.e_flt));
        end
        tbl.delete();
    endtask

    initial begin
        #12;
        chk("rst_target", 0, int'(target), 0);
        chk("rst_accel", 0, int'(accel), 0);
        chk("rst_decel", 0, int'(decel), 0);
        chk("rst_engaged", 0, int'(engaged), 0);
        chk("rst_fault", 0, int'(cmp_fault), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // set, first tick accelerates, next tick decelerates
        add(mk(1,1,0,0,0,0, 60,E,  60,0,0,1,0), 1);
        add(mk(1,0,0,0,0,0, 60,L,  60,0,0,1,0), 15);
        add(mk(1,0,0,0,0,0, 60,L,  60,1,0,1,0), 1);
        add(mk(1,0,0,0,0,0, 60,G,  60,1,0,1,0), 15);
        add(mk(1,0,0,0,0,0, 60,G,  60,0,1,1,0), 1);
        add(mk(1,0,0,0,0,0, 60,L,  60,0,1,1,0), 15);
        add(mk(1,0,0,0,0,0, 60,L,  60,1,0,1,0), 1);
        // brake from ACCEL, then resume with retained target
        add(mk(1,0,0,0,0,1, 60,L,  60,0,0,0,0), 1);
        add(mk(1,0,1,0,0,0, 60,L,  60,0,0,1,0), 1);
        // saturating adjust and latch clamp
        add(mk(1,1,0,0,0,0,199,E, 199,0,0,1,0), 1);
        add(mk(1,0,0,1,0,0,199,E, 200,0,0,1,0), 3);
        add(mk(1,1,0,0,0,0,  1,E,   1,0,0,1,0), 1);
        add(mk(1,0,0,0,1,0,  1,E,   0,0,0,1,0), 2);
        add(mk(1,0,0,1,1,0,  1,E,   0,0,0,1,0), 1);
        add(mk(1,1,0,0,0,0,250,E, 200,0,0,1,0), 1);
        add(mk(1,1,0,1,0,0,100,E, 100,0,0,1,0), 1);
        // non-one-hot comparator at a tick, fault is sticky
        add(mk(1,0,0,0,0,0,100,LG,100,0,0,1,0), 15);
        add(mk(1,0,0,0,0,0,100,LG,100,0,0,1,1), 1);
        add(mk(1,0,0,0,0,0,100,E, 100,0,0,1,1), 16);
        add(mk(0,0,0,0,0,0,100,E, 100,0,0,0,1), 1);
        add(mk(1,0,0,1,0,0,100,E, 100,0,0,0,1), 1);
        add(mk(1,0,1,0,0,0,100,E, 100,0,0,0,1), 1);
        // back into ACCEL before the async reset
        add(mk(1,1,0,0,0,0, 60,L,  60,0,0,1,1), 1);
        add(mk(1,0,0,0,0,0, 60,L,  60,0,0,1,1), 15);
        add(mk(1,0,0,0,0,0, 60,L,  60,1,0,1,1), 1);
        run_table();

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_accel", step_no, int'(accel), 0);
        chk("async_target", step_no, int'(target), 0);
        chk("async_engaged", step_no, int'(engaged), 0);
        chk("async_fault", step_no, int'(cmp_fault), 0);
        @(negedge clk);
        rst_n = 1'b1;

        add(mk(1,0,1,0,0,0, 60,L,   0,0,0,0,0), 1);
        add(mk(1,0,0,0,0,0, 60,L,   0,0,0,0,0), 2);
        run_table();

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
